// File: rtl/apb_master_if_if.sv
// Bus bundle for apb_master_if: host request/response channel plus the APB master signals.
interface apb_master_if_if #(
    parameter int APB_DATA_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 32
);
    localparam int STRB_WIDTH = APB_DATA_WIDTH / 8;

    logic                      host_req_valid_in;
    logic                      host_req_ready_out;
    logic [APB_ADDR_WIDTH-1:0] host_addr_in;
    logic                      host_write_in;
    logic [APB_DATA_WIDTH-1:0] host_wdata_in;
    logic [STRB_WIDTH-1:0]     host_strb_in;
    logic [2:0]                host_prot_in;
    logic                      host_rsp_valid_out;
    logic [APB_DATA_WIDTH-1:0] host_rdata_out;
    logic                      host_error_out;
    logic                      host_timeout_out;

    logic [APB_ADDR_WIDTH-1:0] apb_addr_out;
    logic                      apb_psel_out;
    logic                      apb_penable_out;
    logic                      apb_write_out;
    logic [APB_DATA_WIDTH-1:0] apb_wdata_out;
    logic [STRB_WIDTH-1:0]     apb_strb_out;
    logic [2:0]                apb_prot_out;
    logic [APB_DATA_WIDTH-1:0] apb_rdata_in;
    logic                      apb_ready_in;
    logic                      apb_slverr_in;

    modport master (
        input  host_req_valid_in, host_addr_in, host_write_in, host_wdata_in,
               host_strb_in, host_prot_in, apb_rdata_in, apb_ready_in, apb_slverr_in,
        output host_req_ready_out, host_rsp_valid_out, host_rdata_out, host_error_out,
               host_timeout_out, apb_addr_out, apb_psel_out, apb_penable_out,
               apb_write_out, apb_wdata_out, apb_strb_out, apb_prot_out
    );

    modport slave (
        output host_req_valid_in, host_addr_in, host_write_in, host_wdata_in,
               host_strb_in, host_prot_in, apb_rdata_in, apb_ready_in, apb_slverr_in,
        input  host_req_ready_out, host_rsp_valid_out, host_rdata_out, host_error_out,
               host_timeout_out, apb_addr_out, apb_psel_out, apb_penable_out,
               apb_write_out, apb_wdata_out, apb_strb_out, apb_prot_out
    );
endinterface

// File: rtl/apb_master_if.sv
// APB master front-end: one host request at a time becomes an APB SETUP/ACCESS transfer,
// with an ACCESS-phase wait timeout so a stuck slave cannot hang the host.
module apb_master_if #(
    parameter int APB_DATA_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLE  = 16
) (
    input logic             apb_clk_in,
    input logic             apb_rstn_in,
    apb_master_if_if.master bus
);
    localparam int STRB_WIDTH = APB_DATA_WIDTH / 8;
    localparam int CNT_W      = $clog2(TIMEOUT_CYCLE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLE - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            state                  <= IDLE;
            wait_cnt               <= '0;
            bus.host_req_ready_out <= 1'b0;
            bus.host_rsp_valid_out <= 1'b0;
            bus.host_rdata_out     <= '0;
            bus.host_error_out     <= 1'b0;
            bus.host_timeout_out   <= 1'b0;
            bus.apb_addr_out       <= '0;
            bus.apb_psel_out       <= 1'b0;
            bus.apb_penable_out    <= 1'b0;
            bus.apb_write_out      <= 1'b0;
            bus.apb_wdata_out      <= '0;
            bus.apb_strb_out       <= '0;
            bus.apb_prot_out       <= '0;
        end else begin
            bus.host_rsp_valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.host_req_valid_in && bus.host_req_ready_out) begin
                        bus.apb_addr_out       <= bus.host_addr_in;
                        bus.apb_write_out      <= bus.host_write_in;
                        bus.apb_prot_out       <= bus.host_prot_in;
                        bus.apb_wdata_out      <= bus.host_write_in ? bus.host_wdata_in : '0;
                        bus.apb_strb_out       <= bus.host_write_in ? bus.host_strb_in : '0;
                        bus.apb_psel_out       <= 1'b1;
                        bus.apb_penable_out    <= 1'b0;
                        bus.host_req_ready_out <= 1'b0;
                        state                  <= SETUP;
                    end else begin
                        bus.host_req_ready_out <= 1'b1;
                    end
                end
                SETUP: begin
                    bus.apb_penable_out <= 1'b1;
                    wait_cnt            <= '0;
                    state               <= ACCESS;
                end
                ACCESS: begin
                    // PREADY wins over a timeout landing on the same cycle
                    if (bus.apb_ready_in) begin
                        bus.host_rdata_out     <= bus.apb_write_out ? '0 : bus.apb_rdata_in;
                        bus.host_error_out     <= bus.apb_slverr_in;
                        bus.host_timeout_out   <= 1'b0;
                        bus.apb_psel_out       <= 1'b0;
                        bus.apb_penable_out    <= 1'b0;
                        bus.host_rsp_valid_out <= 1'b1;
                        state                  <= RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        bus.host_rdata_out     <= '0;
                        bus.host_error_out     <= 1'b1;
                        bus.host_timeout_out   <= 1'b1;
                        bus.apb_psel_out       <= 1'b0;
                        bus.apb_penable_out    <= 1'b0;
                        bus.host_rsp_valid_out <= 1'b1;
                        state                  <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    bus.host_req_ready_out <= 1'b1;
                    state                  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master_if.sv
// Randomized bench for apb_master_if with a transaction-level reference model.
module tb_apb_master_if;
    localparam int T = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    apb_master_if_if #(.APB_DATA_WIDTH(32), .APB_ADDR_WIDTH(32)) bus ();

    apb_master_if #(.APB_DATA_WIDTH(32), .APB_ADDR_WIDTH(32), .TIMEOUT_CYCLE(T)) dut (
        .apb_clk_in (clk),
        .apb_rstn_in(rstn),
        .bus        (bus)
    );

    typedef struct {
        int          wait_n, acc, lat;
        bit          setup_ok, stable, hang, busy_rdy, resp_rdy, rsp, rsp_after, rdy_after;
        logic [31:0] addr, wdata, rdata;
        logic        wr, err, to;
        logic [3:0]  strb;
        logic [2:0]  prot;
    } obs_t;

    // Transfer-level expectation: slave answers after `waits` low cycles unless that exceeds the limit.
    function automatic void model(input logic wr, input int waits, input logic err, input logic [31:0] rd,
                                  output int acc, output logic to, output logic e, output logic [31:0] rdx);
        to  = (waits >= T);
        acc = to ? T : waits + 1;
        e   = to | err;
        rdx = (to || wr) ? 32'h0 : rd;
    endfunction

    // Called at a falling edge; returns at the falling edge of the cycle after RESP.
    task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                           input logic [3:0] st, input logic [2:0] pr, input int waits,
                           input logic err, input logic [31:0] rd, input bit keep, output obs_t o);
        int n;
        int k;
        o = '{default: '0};
        bus.host_addr_in = addr; bus.host_write_in = wr; bus.host_wdata_in = wd;
        bus.host_strb_in = st;   bus.host_prot_in = pr;  bus.host_req_valid_in = 1'b1;
        n = 0;
        while (bus.host_req_ready_out !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        o.wait_n = n;
        if (n >= 20) begin o.hang = 1; bus.host_req_valid_in = 1'b0; return; end
        @(negedge clk);
        if (!keep) bus.host_req_valid_in = 1'b0;
        o.lat = 1;
        o.setup_ok = (bus.apb_psel_out === 1'b1) && (bus.apb_penable_out === 1'b0) &&
                     (bus.host_req_ready_out === 1'b0);
        o.addr = bus.apb_addr_out; o.wr = bus.apb_write_out; o.wdata = bus.apb_wdata_out;
        o.strb = bus.apb_strb_out; o.prot = bus.apb_prot_out; o.stable = 1;
        k = 0;
        forever begin
            @(negedge clk); o.lat++;
            if (!(bus.apb_psel_out === 1'b1 && bus.apb_penable_out === 1'b1)) break;
            if (bus.apb_addr_out !== o.addr || bus.apb_write_out !== o.wr || bus.apb_wdata_out !== o.wdata ||
                bus.apb_strb_out !== o.strb || bus.apb_prot_out !== o.prot) o.stable = 0;
            if (bus.host_req_ready_out !== 1'b0 || bus.host_rsp_valid_out !== 1'b0) o.busy_rdy = 1;
            bus.apb_ready_in  = (k == waits);
            bus.apb_slverr_in = (k == waits) ? err : 1'b1;
            bus.apb_rdata_in  = (k == waits) ? rd : $urandom;
            k++;
            if (k > 40) begin o.hang = 1; break; end
        end
        o.acc = k;
        bus.apb_ready_in = 1'b0; bus.apb_slverr_in = 1'b0; bus.apb_rdata_in = $urandom;
        o.rsp = bus.host_rsp_valid_out; o.rdata = bus.host_rdata_out;
        o.err = bus.host_error_out;     o.to = bus.host_timeout_out;
        o.resp_rdy = bus.host_req_ready_out;
        @(negedge clk);
        o.rsp_after = bus.host_rsp_valid_out;
        o.rdy_after = bus.host_req_ready_out;
        if (bus.apb_addr_out !== o.addr || bus.apb_wdata_out !== o.wdata || bus.apb_prot_out !== o.prot) o.stable = 0;
    endtask

    task automatic test_reset();
        bus.host_req_valid_in = 0; bus.host_addr_in = 0; bus.host_write_in = 0; bus.host_wdata_in = 0;
        bus.host_strb_in = 0; bus.host_prot_in = 0; bus.apb_rdata_in = 0; bus.apb_ready_in = 0;
        bus.apb_slverr_in = 0; rstn = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({bus.host_req_ready_out, bus.host_rsp_valid_out, bus.apb_psel_out, bus.apb_penable_out,
             bus.host_error_out, bus.host_timeout_out, bus.apb_write_out} !== 7'b0 ||
            bus.apb_addr_out !== 32'h0 || bus.host_rdata_out !== 32'h0 || bus.apb_wdata_out !== 32'h0 ||
            bus.apb_strb_out !== 4'h0 || bus.apb_prot_out !== 3'h0) begin
            errors++; $display("FAIL reset_outputs got ready=%b psel=%b addr=%h required all zero",
                               bus.host_req_ready_out, bus.apb_psel_out, bus.apb_addr_out);
        end
        rstn = 1'b1; #1;
        checks++;
        if (bus.host_req_ready_out !== 1'b0) begin errors++; $display("FAIL reset_release_ready got=%b exp=0", bus.host_req_ready_out); end
        @(negedge clk);
        checks++;
        if (bus.host_req_ready_out !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%b exp=1", bus.host_req_ready_out); end
    endtask

    task automatic test_read_zero_wait();
        obs_t o;
        do_xfer(32'h40, 1'b0, 32'h1111_2222, 4'hF, 3'b000, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, o);
        checks++;
        if (o.hang || !o.setup_ok || o.acc !== 1 || o.lat !== 3) begin
            errors++; $display("FAIL rd0_timing got setup=%b acc=%0d lat=%0d exp setup=1 acc=1 lat=3", o.setup_ok, o.acc, o.lat);
        end
        checks++;
        if (o.rsp !== 1'b1 || o.rdata !== 32'hDEAD_BEEF || o.err !== 1'b0 || o.to !== 1'b0) begin
            errors++; $display("FAIL rd0_resp got v=%b rdata=%h err=%b to=%b exp v=1 rdata=deadbeef err=0 to=0", o.rsp, o.rdata, o.err, o.to);
        end
        checks++;
        if (o.addr !== 32'h40 || o.wr !== 1'b0 || o.wdata !== 32'h0 || o.strb !== 4'h0) begin
            errors++; $display("FAIL rd0_bus got addr=%h wr=%b wdata=%h strb=%h exp 40/0/0/0", o.addr, o.wr, o.wdata, o.strb);
        end
        checks++;
        if (o.rdy_after !== 1'b1 || o.rsp_after !== 1'b0) begin
            errors++; $display("FAIL rd0_after got ready=%b rsp=%b exp ready=1 rsp=0", o.rdy_after, o.rsp_after);
        end
    endtask

    task automatic test_write_waits();
        obs_t o;
        do_xfer(32'h10, 1'b1, 32'hA5A5_A5A5, 4'hF, 3'b010, 3, 1'b0, 32'h1234_5678, 1'b0, o);
        checks++;
        if (o.acc !== 4 || !o.stable || o.busy_rdy) begin
            errors++; $display("FAIL wr3_access got acc=%0d stable=%b busy=%b exp 4/1/0", o.acc, o.stable, o.busy_rdy);
        end
        checks++;
        if (o.addr !== 32'h10 || o.wr !== 1'b1 || o.wdata !== 32'hA5A5_A5A5 || o.strb !== 4'hF || o.prot !== 3'b010) begin
            errors++; $display("FAIL wr3_bus got addr=%h wdata=%h strb=%h prot=%b", o.addr, o.wdata, o.strb, o.prot);
        end
        checks++;
        if (o.rsp !== 1'b1 || o.rdata !== 32'h0 || o.err !== 1'b0 || o.to !== 1'b0) begin
            errors++; $display("FAIL wr3_resp got v=%b rdata=%h err=%b to=%b exp 1/0/0/0", o.rsp, o.rdata, o.err, o.to);
        end
    endtask

    task automatic test_slverr();
        obs_t o;
        do_xfer(32'h84, 1'b0, 32'h0, 4'h0, 3'b001, 2, 1'b1, 32'hCAFE_0001, 1'b0, o);
        checks++;
        if (o.rsp !== 1'b1 || o.err !== 1'b1 || o.to !== 1'b0 || o.rdata !== 32'hCAFE_0001) begin
            errors++; $display("FAIL slverr_set got v=%b err=%b to=%b rdata=%h exp 1/1/0/cafe0001", o.rsp, o.err, o.to, o.rdata);
        end
        do_xfer(32'h88, 1'b0, 32'h0, 4'h0, 3'b001, 2, 1'b0, 32'hCAFE_0002, 1'b0, o);
        checks++;
        if (o.rsp !== 1'b1 || o.err !== 1'b0 || o.to !== 1'b0) begin
            errors++; $display("FAIL slverr_ignored got v=%b err=%b to=%b exp 1/0/0", o.rsp, o.err, o.to);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        do_xfer(32'hF0, 1'b0, 32'h0, 4'h0, 3'b000, 100, 1'b0, 32'h5555_AAAA, 1'b0, o);
        checks++;
        if (o.hang || o.acc !== T || o.lat !== T + 2) begin
            errors++; $display("FAIL timeout_len got acc=%0d lat=%0d exp acc=%0d lat=%0d", o.acc, o.lat, T, T + 2);
        end
        checks++;
        if (o.rsp !== 1'b1 || o.err !== 1'b1 || o.to !== 1'b1 || o.rdata !== 32'h0) begin
            errors++; $display("FAIL timeout_resp got v=%b err=%b to=%b rdata=%h exp 1/1/1/0", o.rsp, o.err, o.to, o.rdata);
        end
        do_xfer(32'hF4, 1'b0, 32'h0, 4'h0, 3'b000, T - 1, 1'b0, 32'h5555_AAAA, 1'b0, o);
        checks++;
        if (o.acc !== T || o.rsp !== 1'b1 || o.err !== 1'b0 || o.to !== 1'b0 || o.rdata !== 32'h5555_AAAA) begin
            errors++; $display("FAIL ready_on_last got acc=%0d err=%b to=%b rdata=%h exp %0d/0/0/5555aaaa", o.acc, o.err, o.to, o.rdata, T);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_rsp;
        bus.host_addr_in = 32'h77; bus.host_write_in = 1'b1; bus.host_wdata_in = 32'hFEED;
        bus.host_strb_in = 4'h3; bus.host_req_valid_in = 1'b1; bus.apb_ready_in = 1'b0;
        @(negedge clk);
        bus.host_req_valid_in = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++;
        if (bus.apb_psel_out !== 1'b1 || bus.apb_penable_out !== 1'b1) begin
            errors++; $display("FAIL rstmid_in_access got psel=%b penable=%b exp 1/1", bus.apb_psel_out, bus.apb_penable_out);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (bus.apb_psel_out !== 1'b0 || bus.apb_penable_out !== 1'b0 || bus.apb_addr_out !== 32'h0 ||
            bus.apb_wdata_out !== 32'h0 || bus.host_req_ready_out !== 1'b0 || bus.host_rsp_valid_out !== 1'b0) begin
            errors++; $display("FAIL rstmid_async got psel=%b penable=%b addr=%h ready=%b exp all 0",
                               bus.apb_psel_out, bus.apb_penable_out, bus.apb_addr_out, bus.host_req_ready_out);
        end
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        saw_rsp = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.host_rsp_valid_out !== 1'b0 || bus.apb_psel_out !== 1'b0) saw_rsp = 1;
            if (i == 0) begin
                checks++;
                if (bus.host_req_ready_out !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", bus.host_req_ready_out); end
            end
        end
        checks++;
        if (saw_rsp) begin errors++; $display("FAIL rstmid_no_rsp got rsp/psel activity=1 exp=0"); end
    endtask

    task automatic test_back_to_back();
        obs_t a, b;
        do_xfer(32'h100, 1'b0, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'hAAAA_0001, 1'b1, a);
        do_xfer(32'h104, 1'b1, 32'h0BAD_F00D, 4'h5, 3'b100, 1, 1'b0, 32'h0, 1'b1, b);
        bus.host_req_valid_in = 1'b0;
        checks++;
        if (a.busy_rdy || a.resp_rdy !== 1'b0 || a.rsp !== 1'b1 || a.rdata !== 32'hAAAA_0001) begin
            errors++; $display("FAIL b2b_first got busy=%b resp_rdy=%b v=%b rdata=%h exp 0/0/1/aaaa0001", a.busy_rdy, a.resp_rdy, a.rsp, a.rdata);
        end
        checks++;
        if (b.wait_n !== 0 || b.addr !== 32'h104 || b.wdata !== 32'h0BAD_F00D || b.strb !== 4'h5 || b.acc !== 2 || b.rsp !== 1'b1) begin
            errors++; $display("FAIL b2b_second got wait=%0d addr=%h wdata=%h acc=%0d v=%b exp 0/104/0badf00d/2/1", b.wait_n, b.addr, b.wdata, b.acc, b.rsp);
        end
        @(negedge clk);
        checks++;
        if (bus.apb_psel_out !== 1'b0) begin errors++; $display("FAIL b2b_no_dup got psel=%b exp=0", bus.apb_psel_out); end
    endtask

    task automatic test_random();
        obs_t o;
        logic wr, err, to_e, e_e;
        logic [31:0] addr, wd, rd, rd_e;
        logic [3:0] st;
        logic [2:0] pr;
        int waits, acc_e;
        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom_range(0, 1)); err = 1'($urandom_range(0, 1));
            addr = $urandom; wd = $urandom; rd = $urandom; st = 4'($urandom); pr = 3'($urandom);
            waits = $urandom_range(0, 6);
            model(wr, waits, err, rd, acc_e, to_e, e_e, rd_e);
            do_xfer(addr, wr, wd, st, pr, waits, err, rd, 1'b0, o);
            checks++;
            if (o.hang || o.acc !== acc_e || o.lat !== acc_e + 2 || !o.stable || !o.setup_ok) begin
                errors++; $display("FAIL rand%0d_flow got acc=%0d lat=%0d stable=%b exp acc=%0d lat=%0d", i, o.acc, o.lat, o.stable, acc_e, acc_e + 2);
            end
            checks++;
            if (o.addr !== addr || o.wr !== wr || o.prot !== pr || o.wdata !== (wr ? wd : 32'h0) || o.strb !== (wr ? st : 4'h0)) begin
                errors++; $display("FAIL rand%0d_bus got addr=%h wr=%b wdata=%h strb=%h exp addr=%h wr=%b", i, o.addr, o.wr, o.wdata, o.strb, addr, wr);
            end
            checks++;
            if (o.rsp !== 1'b1 || o.rdata !== rd_e || o.err !== e_e || o.to !== to_e || o.rsp_after !== 1'b0 || o.rdy_after !== 1'b1) begin
                errors++; $display("FAIL rand%0d_resp got v=%b rdata=%h err=%b to=%b exp rdata=%h err=%b to=%b", i, o.rsp, o.rdata, o.err, o.to, rd_e, e_e, to_e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_waits();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got no completion exp completion before 300000");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/apb_master_if.md
Name: apb_master_if

Overview:
APB master front-end that turns single-beat host requests into APB SETUP/ACCESS transfers. It drives the slave-side APB bus consumed by the team's APB slave interface.
- Host side: valid/ready request channel plus a one-cycle response strobe.
- Includes an ACCESS-phase wait timeout, so a stuck slave cannot hang the host.

Parameters:
APB_DATA_WIDTH, 32, data bus width in bits (multiple of 8)
APB_ADDR_WIDTH, 32, address bus width in bits
TIMEOUT_CYCLE, 16, max consecutive ACCESS cycles with apb_ready_in low before abort (>=1)
STRB_WIDTH, APB_DATA_WIDTH/8, localparam, write-strobe width

Ports:
apb_clk_in  input  1  clock, all logic on rising edge
apb_rstn_in  input  1  asynchronous active-low reset
host_req_valid_in  input  1  host request valid
host_req_ready_out  output  1  block can accept a request
host_addr_in  input  APB_ADDR_WIDTH  request address
host_write_in  input  1  1=write, 0=read
host_wdata_in  input  APB_DATA_WIDTH  write data
host_strb_in  input  STRB_WIDTH  write byte strobes
host_prot_in  input  3  protection attributes
host_rsp_valid_out  output  1  one-cycle response strobe
host_rdata_out  output  APB_DATA_WIDTH  read data (0 for writes)
host_error_out  output  1  slave error or timeout
host_timeout_out  output  1  transfer aborted by timeout
apb_addr_out  output  APB_ADDR_WIDTH  PADDR
apb_psel_out  output  1  PSEL
apb_penable_out  output  1  PENABLE
apb_write_out  output  1  PWRITE
apb_wdata_out  output  APB_DATA_WIDTH  PWDATA
apb_strb_out  output  STRB_WIDTH  PSTRB
apb_prot_out  output  3  PPROT
apb_rdata_in  input  APB_DATA_WIDTH  PRDATA
apb_ready_in  input  1  PREADY
apb_slverr_in  input  1  PSLVERR (tie 0 if unused)

Behaviour:
- Clock apb_clk_in; reset apb_rstn_in, asynchronous, active-low. All outputs are registered.
- Reset values: every output is 0, including host_req_ready_out; FSM goes to IDLE. host_req_ready_out rises in the first clock after reset release.
- Reset mid-transfer: psel/penable drop immediately, the transfer is discarded, and no response is issued.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - host_req_ready_out=1.
  - On a rising edge with valid&&ready: latch addr/write/prot into the apb_* outputs. For writes, latch wdata and strb. For reads, drive apb_wdata_out=0 and apb_strb_out=0.
  - Then set psel=1, penable=0, ready=0, and go to SETUP.
  - Valid without ready is ignored; the host holds its request.
- SETUP: lasts exactly one cycle. Set penable=1, clear the wait counter, go to ACCESS.
- ACCESS, apb_ready_in=1 sampled:
  - host_rdata_out = write ? 0 : apb_rdata_in.
  - host_error_out = apb_slverr_in; host_timeout_out=0.
  - psel=0, penable=0, go to RESP.
- ACCESS, apb_ready_in=0:
  - Increment the counter (width clog2(TIMEOUT_CYCLE+1)).
  - On the TIMEOUT_CYCLE-th consecutive low cycle: psel=0, penable=0, host_rdata_out=0, host_error_out=1, host_timeout_out=1, go to RESP.
  - If ready is high on the cycle that would time out, ready wins and the transfer completes normally.
- apb_slverr_in is only sampled when apb_ready_in=1.
- RESP:
  - host_rsp_valid_out=1 for exactly one cycle; host has no backpressure.
  - Next state IDLE with host_req_ready_out=1.
- Latency: handshake in cycle 0; SETUP in cycle 1; ACCESS in cycle 2. Zero-wait slave gives RESP in cycle 3 and ready again in cycle 4, so the minimum issue interval is 4 cycles.
- Hold rules:
  - apb_addr/write/wdata/strb/prot are stable from SETUP through the end of ACCESS, and keep their last values afterwards.
  - host_rdata/error/timeout keep their values until the next RESP update; they are meaningful only while rsp_valid=1.
- Only one transfer is in flight at a time; there is no queueing.

Test Plan:
- Read, zero wait: addr=0x40, slave ready in first ACCESS with rdata=0xDEADBEEF -> psel in cycles 1-2, penable in cycle 2, rsp_valid in cycle 3 with rdata=0xDEADBEEF, error=0; ready=1 in cycle 4.
- Write, 3 wait states: addr=0x10, wdata=0xA5A5A5A5, strb=0xF, prot=3'b010 -> PADDR/PWDATA/PSTRB/PPROT stable across 4 ACCESS cycles; response rdata=0, error=0.
- Slave error: read with PSLVERR=1 alongside PREADY -> error=1, timeout=0. Also drive PSLVERR=1 while PREADY=0 -> that PSLVERR is ignored.
- Timeout, TIMEOUT_CYCLE=4, ready never asserts -> exactly 4 ACCESS cycles, psel drops, rsp_valid with error=1, timeout=1, rdata=0. Repeat with ready on the 4th cycle -> normal completion.
- Async reset asserted during ACCESS -> psel/penable/outputs go to 0 without a clock edge; no rsp_valid; ready=1 one cycle after release.
- Valid held high continuously with back-to-back requests -> second request accepted only in the cycle after RESP; no request lost or duplicated.
